// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: pointer-based single-clock FIFO with occupancy flags, error pulses, flush and selectable read mode
module sync_fifo_flags #(
  parameter int DEPTH     = 8,
  parameter int DATA_W    = 8,
  parameter int AFULL_TH  = 6,
  parameter int AEMPTY_TH = 1,
  parameter int FWFT      = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          push_data_i,
  input  logic                       pop_i,
  output logic [DATA_W-1:0]          pop_data_o,
  output logic                       pop_valid_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       almost_full_o,
  output logic                       almost_empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o,
  output logic                       underflow_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [DATA_W-1:0] mem [DEPTH];
  logic push_acc, pop_acc;
  assign count_o        = count;
  assign full_o         = count == CW'(DEPTH);
  assign empty_o        = count == '0;
  assign almost_full_o  = count >= CW'(AFULL_TH);
  assign almost_empty_o = count <= CW'(AEMPTY_TH);
  assign pop_acc        = pop_i & ~empty_o;
  assign push_acc       = push_i & (~full_o | pop_i);
  // pointers, occupancy and rejection pulses; flush clears without reporting errors
  always_ff @(posedge clk) begin
    if (!reset || flush_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr + AW'(push_acc);
      rd_ptr      <= rd_ptr + AW'(pop_acc);
      count       <= count + CW'(push_acc) - CW'(pop_acc);
      overflow_o  <= push_i & ~push_acc;
      underflow_o <= pop_i & ~pop_acc;
    end
  end
  // storage is not reset; only accepted pushes write
  always_ff @(posedge clk) begin
    if (reset && !flush_i && push_acc) mem[wr_ptr] <= push_data_i;
  end
  if (FWFT != 0) begin : g_fwft
    assign pop_data_o  = empty_o ? '0 : mem[rd_ptr];
    assign pop_valid_o = ~empty_o;
  end else begin : g_reg
    // registered read: data lands one cycle after the accepted pop and holds otherwise
    always_ff @(posedge clk) begin
      if (!reset) begin
        pop_data_o  <= '0;
        pop_valid_o <= 1'b0;
      end else if (flush_i) begin
        pop_valid_o <= 1'b0;
      end else begin
        pop_valid_o <= pop_acc;
        if (pop_acc) pop_data_o <= mem[rd_ptr];
      end
    end
  end
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: drives registered and fall-through instances in lockstep against a queue model
module tb_sync_fifo_flags;
  localparam int DEPTH = 8;
  localparam int AF = 6;
  localparam int AE = 1;
  logic clk = 0;
  logic reset = 0, flush_i = 0, push_i = 0, pop_i = 0;
  logic [7:0] push_data_i = 0;
  logic [7:0] d0, d1;
  logic v0, v1, f0, f1, e0, e1, af0, af1, ae0, ae1, o0, o1, u0f, u1f;
  logic [3:0] c0, c1;
  int checks = 0, failures = 0;
  logic [7:0] q[$];
  logic [7:0] rd = 0;
  logic rv = 0, ovf = 0, unf = 0;
  always #5 clk = ~clk;
  sync_fifo_flags #(.DEPTH(DEPTH), .DATA_W(8), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(0)) u_reg (
    .clk(clk), .reset(reset), .flush_i(flush_i), .push_i(push_i), .push_data_i(push_data_i),
    .pop_i(pop_i), .pop_data_o(d0), .pop_valid_o(v0), .full_o(f0), .empty_o(e0),
    .almost_full_o(af0), .almost_empty_o(ae0), .count_o(c0), .overflow_o(o0), .underflow_o(u0f));
  sync_fifo_flags #(.DEPTH(DEPTH), .DATA_W(8), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(1)) u_fwft (
    .clk(clk), .reset(reset), .flush_i(flush_i), .push_i(push_i), .push_data_i(push_data_i),
    .pop_i(pop_i), .pop_data_o(d1), .pop_valid_o(v1), .full_o(f1), .empty_o(e1),
    .almost_full_o(af1), .almost_empty_o(ae1), .count_o(c1), .overflow_o(o1), .underflow_o(u1f));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic r, input logic fl, input logic pu, input logic po, input logic [7:0] d);
    int n;
    logic can_pop, can_push;
    reset = r; flush_i = fl; push_i = pu; pop_i = po; push_data_i = d;
    @(posedge clk);
    #1;
    n = q.size();
    if (!r) begin
      q.delete(); rd = 0; rv = 0; ovf = 0; unf = 0;
    end else if (fl) begin
      q.delete(); rv = 0; ovf = 0; unf = 0;
    end else begin
      can_pop = po && n > 0;
      can_push = pu && (n < DEPTH || po);
      rv = can_pop;
      if (can_pop) rd = q.pop_front();
      if (can_push) q.push_back(d);
      ovf = pu && !can_push;
      unf = po && !can_pop;
    end
    n = q.size();
    chk("count", 32'(c0), 32'(n));
    chk("empty", 32'(e0), 32'(n == 0));
    chk("full", 32'(f0), 32'(n == DEPTH));
    chk("almost_full", 32'(af0), 32'(n >= AF));
    chk("almost_empty", 32'(ae0), 32'(n <= AE));
    chk("overflow", 32'(o0), 32'(ovf));
    chk("underflow", 32'(u0f), 32'(unf));
    chk("reg_valid", 32'(v0), 32'(rv));
    chk("reg_data", 32'(d0), 32'(rd));
    chk("fwft_count", 32'(c1), 32'(n));
    chk("fwft_overflow", 32'(o1), 32'(ovf));
    chk("fwft_underflow", 32'(u1f), 32'(unf));
    chk("fwft_valid", 32'(v1), 32'(n > 0));
    chk("fwft_data", 32'(d1), n > 0 ? 32'(q[0]) : 32'h0);
  endtask
  initial begin
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 8'h77);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 1, 0, 8'(8'h10 + i));
    step(1, 0, 1, 0, 8'hAA);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 1, 0, 8'($urandom));
    step(1, 0, 1, 1, 8'hC3);
    for (int i = 0; i < 9; i++) step(1, 0, 0, 1, 0);
    step(1, 0, 1, 1, 8'h55);
    step(1, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 8'($urandom));
    for (int i = 0; i < 20; i++) step(1, 0, 1, 1, 8'($urandom));
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 1, 0, 8'($urandom));
    step(1, 1, 1, 0, 8'h99);
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 8'h3C);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 8'($urandom));
    step(0, 0, 1, 0, 8'hEE);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 49) != 0, $urandom_range(0, 29) == 0,
           1'($urandom), 1'($urandom), 8'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
